// File: rtl/mmio_avst_to_avmm_bridge.sv
// mmio_avst_to_avmm_bridge: host MMIO Avalon-ST command/response to single-beat Avalon-MM master
module mmio_avst_to_avmm_bridge #(
    parameter int ADDR_W         = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic [83:0]       avst_mmio_cmd_data,
    input  logic              avst_mmio_cmd_valid,
    output logic              avst_mmio_cmd_ready,
    output logic [63:0]       avst_mmio_rsp_data,
    output logic              avst_mmio_rsp_valid,
    input  logic              avst_mmio_rsp_ready,
    output logic [ADDR_W-1:0] avmm_address,
    output logic              avmm_read,
    output logic              avmm_write,
    output logic [63:0]       avmm_writedata,
    output logic [7:0]        avmm_byteenable,
    input  logic              avmm_waitrequest,
    input  logic [63:0]       avmm_readdata,
    input  logic              avmm_readdatavalid,
    output logic [7:0]        timeout_count
);
    typedef enum logic [2:0] {IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT, RSP} state_t;
    state_t      state, state_next;
    logic [15:0] timer;
    logic [15:0] cmd_addr;
    logic [63:0] cmd_wd;
    logic        drop_pending, drop_next, size_q, hi_q;
    logic        accept, timer_done, timeout_hit;
    logic        unused_bits;
    assign cmd_addr    = avst_mmio_cmd_data[79:64];
    assign cmd_wd      = avst_mmio_cmd_data[63:0];
    assign unused_bits = ^{avst_mmio_cmd_data[83:82], cmd_addr[1:0]};
    assign accept      = state == IDLE && avst_mmio_cmd_valid && avst_mmio_cmd_ready;
    assign timer_done  = timer == 16'(TIMEOUT_CYCLES - 1);
    assign timeout_hit = state == RD_WAIT && !avmm_readdatavalid && timer_done;
    // a late beat from an abandoned read, or a quiet IDLE window, retires the drop flag
    assign drop_next   = timeout_hit ? 1'b1 :
                         (drop_pending && (avmm_readdatavalid || (state == IDLE && timer_done))) ? 1'b0 :
                         drop_pending;
    // state register
    always_ff @(posedge clk_clk) begin
        if (reset_reset) state <= IDLE;
        else             state <= state_next;
    end
    // next-state decode
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (accept) state_next = avst_mmio_cmd_data[80] ? WR_ISSUE : RD_ISSUE;
            WR_ISSUE: if (!avmm_waitrequest) state_next = IDLE;
            RD_ISSUE: if (!avmm_waitrequest) state_next = RD_WAIT;
            RD_WAIT:  if (avmm_readdatavalid || timer_done) state_next = RSP;
            RSP:      if (avst_mmio_rsp_ready) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end
    // registered outputs, command latch, read capture and timeout bookkeeping
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            avst_mmio_cmd_ready <= 1'b0;
            avst_mmio_rsp_valid <= 1'b0;
            avst_mmio_rsp_data  <= '0;
            avmm_read           <= 1'b0;
            avmm_write          <= 1'b0;
            avmm_address        <= '0;
            avmm_writedata      <= '0;
            avmm_byteenable     <= '0;
            timeout_count       <= '0;
            drop_pending        <= 1'b0;
            timer               <= '0;
            size_q              <= 1'b0;
            hi_q                <= 1'b0;
        end else begin
            avst_mmio_cmd_ready <= state_next == IDLE && !drop_next;
            avst_mmio_rsp_valid <= state_next == RSP;
            avmm_write          <= state_next == WR_ISSUE;
            avmm_read           <= state_next == RD_ISSUE;
            drop_pending        <= drop_next;
            timer               <= (state == RD_WAIT || (state == IDLE && drop_pending)) ? timer + 16'd1 : 16'd0;
            if (timeout_hit && timeout_count != 8'hFF) timeout_count <= timeout_count + 8'd1;
            if (accept) begin
                avmm_address    <= {cmd_addr[ADDR_W-1:3], 3'b000};
                avmm_byteenable <= avst_mmio_cmd_data[81] ? 8'hFF : cmd_addr[2] ? 8'hF0 : 8'h0F;
                avmm_writedata  <= avst_mmio_cmd_data[81] ? cmd_wd : {cmd_wd[31:0], cmd_wd[31:0]};
                size_q          <= avst_mmio_cmd_data[81];
                hi_q            <= cmd_addr[2];
            end
            if (state == RD_WAIT && avmm_readdatavalid)
                avst_mmio_rsp_data <= size_q ? avmm_readdata :
                                      {32'h0, hi_q ? avmm_readdata[63:32] : avmm_readdata[31:0]};
            else if (timeout_hit)
                avst_mmio_rsp_data <= 64'hFFFF_FFFF_FFFF_FFFF;
        end
    end
endmodule

// File: tb/tb_mmio_avst_to_avmm_bridge.sv
// tb_mmio_avst_to_avmm_bridge: directed self-checking bench for the MMIO bridge
module tb_mmio_avst_to_avmm_bridge;
    logic        clk_clk = 1'b0;
    logic        reset_reset = 1'b1;
    logic [83:0] cmd_data = '0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [63:0] rsp_data;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] address;
    logic        rd, wr;
    logic [63:0] writedata;
    logic [7:0]  byteenable;
    logic        waitrequest = 1'b0;
    logic [63:0] readdata = '0;
    logic        readdatavalid = 1'b0;
    logic [7:0]  timeout_count;
    int          n_checks = 0;
    int          n_errors = 0;
    int          n;

    mmio_avst_to_avmm_bridge #(.ADDR_W(16), .TIMEOUT_CYCLES(8)) dut (
        .clk_clk(clk_clk),
        .reset_reset(reset_reset),
        .avst_mmio_cmd_data(cmd_data),
        .avst_mmio_cmd_valid(cmd_valid),
        .avst_mmio_cmd_ready(cmd_ready),
        .avst_mmio_rsp_data(rsp_data),
        .avst_mmio_rsp_valid(rsp_valid),
        .avst_mmio_rsp_ready(rsp_ready),
        .avmm_address(address),
        .avmm_read(rd),
        .avmm_write(wr),
        .avmm_writedata(writedata),
        .avmm_byteenable(byteenable),
        .avmm_waitrequest(waitrequest),
        .avmm_readdata(readdata),
        .avmm_readdatavalid(readdatavalid),
        .timeout_count(timeout_count)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk_clk);
    endtask

    function automatic logic [83:0] mk(input logic w, input logic s, input logic [15:0] a, input logic [63:0] d);
        return {2'b00, s, w, a, d};
    endfunction

    task automatic wait_ready;
        int k = 0;
        while (!cmd_ready && k < 50) begin
            tick;
            k++;
        end
        check("cmd_ready_wait", cmd_ready, 1);
    endtask

    task automatic send(input logic [83:0] c);
        wait_ready;
        cmd_data  = c;
        cmd_valid = 1'b1;
        tick;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int cnt);
        cnt = 0;
        while (!rsp_valid && cnt < 40) begin
            tick;
            cnt++;
        end
        check("rsp_wait", rsp_valid, 1);
    endtask

    initial begin
        tick;
        tick;
        check("rst_ctrl", {cmd_ready, rsp_valid, rd, wr, byteenable, timeout_count, address}, 0);
        check("rst_rdata", rsp_data, 0);
        check("rst_wdata", writedata, 0);
        reset_reset = 1'b0;
        tick;
        check("ready_after_rst", cmd_ready, 1);

        // 64-bit posted write
        send(mk(1, 1, 16'h0040, 64'h1122334455667788));
        check("wr64_fields", {wr, rd, byteenable, address}, {1'b1, 1'b0, 8'hFF, 16'h0040});
        check("wr64_data", writedata, 64'h1122334455667788);
        check("wr64_ready", cmd_ready, 0);
        tick;
        check("wr64_pulse_end", wr, 0);
        check("wr64_no_rsp", rsp_valid, 0);
        check("wr64_ready_back", cmd_ready, 1);

        // 32-bit read of upper half, response backpressured 4 cycles
        send(mk(0, 0, 16'h0044, 64'h0));
        check("rd32_fields", {rd, wr, byteenable, address}, {1'b1, 1'b0, 8'hF0, 16'h0040});
        tick;
        check("rd32_strobe_end", rd, 0);
        tick;
        tick;
        readdata = 64'hAAAA_BBBB_CCCC_DDDD;
        readdatavalid = 1'b1;
        tick;
        readdatavalid = 1'b0;
        readdata = '0;
        for (int i = 0; i < 4; i++) begin
            check("rd32_rsp_valid", rsp_valid, 1);
            check("rd32_rsp_data", rsp_data, 64'h0000_0000_AAAA_BBBB);
            tick;
        end
        check("rd32_rsp_hold", {rsp_valid, rsp_data}, {1'b1, 64'h0000_0000_AAAA_BBBB});
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        check("rd32_rsp_done", rsp_valid, 0);
        check("rd32_ready_back", cmd_ready, 1);

        // 32-bit write, low half, waitrequest high for 5 cycles
        waitrequest = 1'b1;
        send(mk(1, 0, 16'h000B, 64'hDEADBEEF_CAFEF00D));
        for (int i = 0; i < 6; i++) begin
            check("wrbp_fields", {wr, byteenable, address, cmd_ready}, {1'b1, 8'h0F, 16'h0008, 1'b0});
            check("wrbp_data", writedata, 64'hCAFEF00D_CAFEF00D);
            if (i == 5) waitrequest = 1'b0;
            tick;
        end
        check("wrbp_release", wr, 0);

        // timeout, late beat discarded
        send(mk(0, 1, 16'h0100, 64'h0));
        wait_rsp(n);
        check("to_latency", n, 9);
        check("to_data", rsp_data, 64'hFFFF_FFFF_FFFF_FFFF);
        check("to_count1", timeout_count, 1);
        check("to_ready_blocked", cmd_ready, 0);
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        check("to_rsp_done", {rsp_valid, cmd_ready}, 0);
        tick;
        check("to_drop_wait1", cmd_ready, 0);
        tick;
        check("to_drop_wait2", cmd_ready, 0);
        readdata = 64'h77;
        readdatavalid = 1'b1;
        tick;
        readdatavalid = 1'b0;
        check("to_drop_cleared", cmd_ready, 1);
        check("to_no_second_rsp", rsp_valid, 0);
        tick;
        check("to_no_second_rsp2", rsp_valid, 0);

        // timeout, drop flag retired by IDLE expiry
        send(mk(0, 1, 16'h0108, 64'h0));
        wait_rsp(n);
        check("to2_data", rsp_data, 64'hFFFF_FFFF_FFFF_FFFF);
        check("to2_count", timeout_count, 2);
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        n = 0;
        while (!cmd_ready && n < 40) begin
            tick;
            n++;
        end
        check("to2_idle_expiry", n, 8);

        // data on the final timer cycle wins over timeout
        send(mk(0, 1, 16'h0110, 64'h0));
        repeat (8) tick;
        readdata = 64'h5;
        readdatavalid = 1'b1;
        tick;
        readdatavalid = 1'b0;
        check("race_valid", rsp_valid, 1);
        check("race_data", rsp_data, 64'h5);
        check("race_count", timeout_count, 2);
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        check("race_no_drop", {rsp_valid, cmd_ready}, {1'b0, 1'b1});

        // spurious readdatavalid in IDLE
        readdata = 64'h99;
        readdatavalid = 1'b1;
        tick;
        readdatavalid = 1'b0;
        tick;
        check("spurious_ignored", {rsp_valid, cmd_ready}, {1'b0, 1'b1});

        // reset during RD_WAIT, then a clean read
        send(mk(0, 1, 16'h0200, 64'h0));
        tick;
        tick;
        reset_reset = 1'b1;
        tick;
        check("midrst_ctrl", {cmd_ready, rsp_valid, rd, wr, byteenable, timeout_count, address}, 0);
        check("midrst_rdata", rsp_data, 0);
        check("midrst_wdata", writedata, 0);
        reset_reset = 1'b0;
        send(mk(0, 0, 16'h0010, 64'h0));
        check("post_rst_fields", {rd, byteenable, address}, {1'b1, 8'h0F, 16'h0010});
        tick;
        readdata = 64'h12345678_90ABCDEF;
        readdatavalid = 1'b1;
        tick;
        readdatavalid = 1'b0;
        check("post_rst_rsp", {rsp_valid, rsp_data}, {1'b1, 64'h0000_0000_90AB_CDEF});
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        check("post_rst_done", {rsp_valid, cmd_ready, timeout_count}, {1'b0, 1'b1, 8'h00});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mmio_avst_to_avmm_bridge.md
Name: mmio_avst_to_avmm_bridge

Overview:
- Converts the host MMIO Avalon-ST command stream (84-bit cmd, 64-bit rsp) into single-beat Avalon-MM master transactions toward the board CSR fabric, including kernel_cra.
- Sits directly upstream of the system top's avst_mmio_cmd/avst_mmio_rsp pair.
- Writes are posted. Reads are strictly one-outstanding, with a timeout guard so a hung slave cannot stall the host.

Parameters:
- ADDR_W, 16, width of avmm_address (byte address).
- TIMEOUT_CYCLES, 1024, cycles in RD_WAIT before a read is abandoned; legal range 2..65535.

Ports:
- clk_clk  in  1  bridge clock.
- reset_reset  in  1  reset.
- avst_mmio_cmd_data  in  84  command word:
  - [63:0] writedata
  - [79:64] byte address
  - [80] 1=write / 0=read
  - [81] 1=64-bit / 0=32-bit
  - [83:82] reserved, ignored
- avst_mmio_cmd_valid  in  1  command valid.
- avst_mmio_cmd_ready  out  1  command accepted when valid&ready.
- avst_mmio_rsp_data  out  64  read response data.
- avst_mmio_rsp_valid  out  1  response valid.
- avst_mmio_rsp_ready  in  1  response consumed when valid&ready.
- avmm_address  out  ADDR_W  byte address, bits[2:0] forced 0.
- avmm_read  out  1  read strobe.
- avmm_write  out  1  write strobe.
- avmm_writedata  out  64  write data.
- avmm_byteenable  out  8  byte enables.
- avmm_waitrequest  in  1  slave stall.
- avmm_readdata  in  64  read data.
- avmm_readdatavalid  in  1  read data valid.
- timeout_count  out  8  saturating count of abandoned reads.

Behaviour:
- Reset:
  - Clock and reset are decided: one clock, clk_clk; reset_reset is synchronous, active-high.
  - Reset values: state=IDLE; avst_mmio_cmd_ready=0, avst_mmio_rsp_valid=0, avst_mmio_rsp_data=0; avmm_read=0, avmm_write=0, avmm_address=0, avmm_writedata=0, avmm_byteenable=0; timeout_count=0; drop_pending=0; timer=0.
  - Reset mid-transaction aborts immediately: strobes drop the next cycle, and any pending response is lost.
- States: IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT, RSP.
- Command acceptance:
  - avst_mmio_cmd_ready is registered and equals 1 only in IDLE with drop_pending=0.
  - The accept cycle latches address, data, size and dir.
  - In the next cycle avmm_write or avmm_read is asserted (1-cycle latency).
- Byte enables and data:
  - 64-bit: byteenable=8'hFF.
  - 32-bit: byteenable = addr[2] ? 8'hF0 : 8'h0F, and writedata = {wd[31:0], wd[31:0]}.
- WR_ISSUE: hold avmm_write and all fields stable while waitrequest=1. On the first cycle with waitrequest=0, deassert next cycle and go to IDLE. No response is generated.
- RD_ISSUE: hold avmm_read while waitrequest=1. On waitrequest=0 go to RD_WAIT; clear timer.
- RD_WAIT:
  - timer increments each cycle.
  - readdatavalid=1: capture data and go to RSP. For a 64-bit read, rsp_data=readdata. For a 32-bit read, rsp_data = {32'h0, addr[2] ? readdata[63:32] : readdata[31:0]}.
  - If readdatavalid=1 in the same cycle the timer reaches TIMEOUT_CYCLES-1, the data wins: no timeout.
  - Timer reaches TIMEOUT_CYCLES-1 without data: rsp_data=64'hFFFF_FFFF_FFFF_FFFF; set drop_pending; timeout_count+=1, saturating at 255; go to RSP.
- RSP:
  - rsp_valid=1 starting the cycle after capture.
  - rsp_data is held stable until rsp_ready=1; valid deasserts the next cycle; return to IDLE.
- drop_pending:
  - While set, the next readdatavalid is discarded and clears the flag.
  - It also clears after a further TIMEOUT_CYCLES cycles in IDLE, measured by the reused timer.
  - cmd_ready stays 0 while it is set.
- Spurious readdatavalid outside RD_WAIT with drop_pending=0 is ignored.
- cmd_valid asserted in non-IDLE states is not accepted, because ready=0.

Test Plan:
- 64-bit write: cmd {addr=16'h0040, wr=1, size=1, wd=64'h1122334455667788}, waitrequest low -> avmm_write pulses for exactly 1 cycle with address 16'h0040, byteenable FF, writedata 1122334455667788; no rsp_valid.
- 32-bit read of upper half: cmd addr=16'h0044 read size=0; slave returns readdata=64'hAAAA_BBBB_CCCC_DDDD 3 cycles later -> avmm_address=16'h0040, byteenable F0, rsp_data=64'h0000_0000_AAAA_BBBB.
- Backpressure: waitrequest held high for 5 cycles on a write -> avmm_write and fields stable for all 6 cycles; cmd_ready=0 throughout. Same read with rsp_ready low for 4 cycles -> rsp_valid and rsp_data stable.
- Timeout with TIMEOUT_CYCLES=8: read with no readdatavalid -> rsp_data all-ones; timeout_count=1; cmd_ready stays 0 until a late readdatavalid arrives and is discarded (no second rsp_valid); then cmd_ready=1.
- Simultaneous data and timeout: readdatavalid on the last timer cycle with readdata=64'h5 -> rsp_data=5, timeout_count unchanged, drop_pending=0.
- Reset mid-read: assert reset_reset in RD_WAIT -> next cycle all outputs are at their reset values; after release, a new read completes normally.
